// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive peripheral: FSM state encoding,
// MMIO register offsets and STATUS register bit positions.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic [31:0] SERIAL_DATA_OFF   = 32'd0;
    localparam logic [31:0] SERIAL_STATUS_OFF = 32'd4;

    localparam int NONEMPTY  = 0;
    localparam int FULL      = 1;
    localparam int OVR       = 2;
    localparam int FERR      = 3;
    localparam int PERR      = 4;
    localparam int COUNT_LSB = 8;

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous receive FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguishable without a separate occupancy register.
// A push into a full FIFO is refused (drop) unless a pop lands on the same edge.
module serial_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Pointer update; both may advance on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because reads are qualified by empty.
    always_ff @(posedge clock) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_rx.sv
// MMIO UART receiver: 8N1 deserialiser feeding a small FIFO, read by the CPU
// through DATA (pops) and STATUS (clears sticky error flags).
// Optional even-parity frame checking is enabled by defining SERIAL_RX_PARITY_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rs
// START     | counting to start-bit centre; high there means glitch
// DATA      | sampling 8 data bits LSB first, one per bit period
// PARITY    | sampling the even-parity bit (SERIAL_RX_PARITY_EN only)
// STOP      | sampling stop bit; high pushes the byte, low is a framing error
// WAIT_IDLE | line held low after a bad stop bit, waiting for it to release
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        sel,
    input  logic        re,
    input  logic [31:0] addr,
    output logic [31:0] dout
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rs;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick;
    logic          push;
    logic          pop;
    logic          rd_status;
    logic          is_data;
    logic          is_status;
    logic          ovr;
    logic          ferr;
    logic          perr;
    logic          ferr_set;
    logic          ovr_set;
    logic [7:0]    head;
    logic [AW:0]   fifo_count;
    logic          full;
    logic          empty;
    logic [31:0]   status_word;
    logic [31:0]   data_word;
    logic          unused_addr;

    assign is_data     = (addr[2] == SERIAL_DATA_OFF[2]);
    assign is_status   = (addr[2] == SERIAL_STATUS_OFF[2]);
    assign unused_addr = ^{addr[31:3], addr[1:0]};
    assign pop         = sel & re & is_data;
    assign rd_status   = sel & re & is_status;
    assign tick        = (baud_cnt == FULL_TC);
    assign ferr_set    = (state == STOP) && tick && !rs;

`ifdef SERIAL_RX_PARITY_EN
    logic par_bad;
    logic perr_set;
    assign perr_set = (state == PARITY) && tick && (rs != ^shreg);
    assign push     = (state == STOP) && tick && rs && !par_bad;
`else
    assign push     = (state == STOP) && tick && rs;
    assign perr     = 1'b0;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    // Frame FSM with baud and bit counters; counters only wrap through explicit clears.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!rs) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_TC) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        shreg    <= {rs, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        par_bad  <= (rs != ^shreg);
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        state    <= rs ? IDLE : WAIT_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags: a STATUS read clears them, a same-cycle set wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            ovr  <= ovr_set  | (ovr  & ~rd_status);
            ferr <= ferr_set | (ferr & ~rd_status);
`ifdef SERIAL_RX_PARITY_EN
            perr <= perr_set | (perr & ~rd_status);
`endif
        end
    end

    serial_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .head  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty),
        .drop  (ovr_set)
    );

    // Read mux assembling the DATA and STATUS words.
    always_comb begin
        status_word                    = '0;
        status_word[NONEMPTY]          = ~empty;
        status_word[FULL]              = full;
        status_word[OVR]               = ovr;
        status_word[FERR]              = ferr;
        status_word[PERR]              = perr;
        status_word[COUNT_LSB +: 8]    = 8'(fifo_count);
        data_word                      = empty ? 32'd0 : {23'd0, 1'b1, head};
        dout                           = is_status ? status_word : data_word;
    end

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        sel   = 1'b0;
    logic        re    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] dout;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    byte unsigned mq[$];
    bit m_ovr  = 1'b0;
    bit m_ferr = 1'b0;
    bit m_perr = 1'b0;

    always #5 clock = ~clock;

    serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .sel   (sel),
        .re    (re),
        .addr  (addr),
        .dout  (dout)
    );

    function automatic logic [31:0] model_dout(input logic a2);
        logic [31:0] w;
        w = 32'd0;
        if (a2) begin
            w[15:8] = 8'(mq.size());
            w[4]    = m_perr;
            w[3]    = m_ferr;
            w[2]    = m_ovr;
            w[1]    = (mq.size() == DEPTH);
            w[0]    = (mq.size() != 0);
        end else if (mq.size() != 0) begin
            w = {23'd0, 1'b1, mq[0]};
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h at %0t", name, got, want, $time);
        end
    endtask

    // Model outcome of one complete frame on the line.
    task automatic model_frame(input logic [7:0] d, input bit par_flip, input bit stop_lvl);
        bit par_ok;
        par_ok = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        par_ok = !par_flip;
        if (!par_ok) m_perr = 1'b1;
`endif
        if (!stop_lvl) m_ferr = 1'b1;
        else if (par_ok) begin
            if (mq.size() == DEPTH) m_ovr = 1'b1;
            else mq.push_back(d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_lvl, input int stop_bits);
        chk_en = 1'b0;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef SERIAL_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (CPB) @(negedge clock);
`endif
        rx = stop_lvl;
        repeat (CPB * stop_bits) @(negedge clock);
        rx = 1'b1;
        model_frame(d, par_flip, stop_lvl);
        repeat (4) @(negedge clock);
        chk_en = 1'b1;
    endtask

    task automatic rd(input logic s, input logic r, input logic a2, input logic [31:0] want, input string name);
        logic [31:0] got;
        sel  = s;
        re   = r;
        addr = ($urandom() & 32'hFFFF_FFFB) | {29'd0, a2, 2'b00};
        #2;
        got = dout;
        check(name, got, want);
        @(posedge clock);
        if (s && r) begin
            if (a2) begin
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
                m_perr = 1'b0;
            end else if (mq.size() != 0) begin
                void'(mq.pop_front());
            end
        end
        @(negedge clock);
        sel = 1'b0;
        re  = 1'b0;
    endtask

    // Per-cycle comparison of dout against the model while the line is quiet.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (chk_en) check($sformatf("cycle_a%0d", addr[2]), dout, model_dout(addr[2]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_en = 1'b1;

        rd(1, 1, 1, 32'h0000_0000, "reset_status");
        rd(1, 1, 0, 32'h0000_0000, "reset_data");

        send_frame(8'hA5, 0, 1, 1);
        rd(1, 1, 0, 32'h0000_01A5, "a5_data");
        rd(1, 1, 0, 32'h0000_0000, "a5_then_empty");

        chk_en = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        chk_en = 1'b1;
        rd(1, 1, 1, 32'h0000_0000, "glitch_status");

        for (int b = 1; b <= 5; b++) send_frame(8'(b), 0, 1, 1);
        rd(1, 1, 1, 32'h0000_0407, "ovr_status");
        rd(1, 1, 1, 32'h0000_0403, "ovr_cleared_status");
        rd(1, 0, 0, 32'h0000_0101, "re_low_no_pop");
        rd(0, 1, 0, 32'h0000_0101, "sel_low_no_pop");
        for (int b = 1; b <= 4; b++) rd(1, 1, 0, 32'h100 | b, $sformatf("drain_%0d", b));
        rd(1, 1, 0, 32'h0000_0000, "drain_empty");

        send_frame(8'h3C, 0, 0, 20);
        send_frame(8'h7E, 0, 1, 1);
        rd(1, 1, 1, 32'h0000_0109, "ferr_status");
        rd(1, 1, 0, 32'h0000_017E, "after_ferr_data");

        send_frame(8'h11, 0, 1, 1);
        chk_en = 1'b0;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h55 >> i) & 1'b1;
            repeat (CPB) @(negedge clock);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clock);
        chk_en = 1'b1;
        rd(1, 1, 1, 32'h0000_0000, "flush_status");
        send_frame(8'h66, 0, 1, 1);
        rd(1, 1, 0, 32'h0000_0166, "post_reset_data");
        rd(1, 1, 0, 32'h0000_0000, "post_reset_empty");

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h03, 1, 1, 1);
        rd(1, 1, 1, 32'h0000_0010, "perr_status");
        send_frame(8'h07, 0, 1, 1);
        rd(1, 1, 0, 32'h0000_0107, "parity_ok_data");
        rd(1, 1, 1, 32'h0000_0000, "parity_final_status");
`endif

        repeat (4) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
